// File: rtl/game_ctrl_pkg.sv
// Shared game definitions: state codes, level limits and field widths.
// Imported by game_ctrl and by the draw/text blocks that decode state and level.
package game_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned LEVEL_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  localparam logic [LEVEL_W-1:0] LEVEL_FIRST = 4'd1;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX   = 4'd15;

  // Next level, holding at LEVEL_MAX.
  function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
    return (lvl == LEVEL_MAX) ? lvl : lvl + LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/game_ctrl_button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, frame-sampled debounce counter and
// a single-cycle press pulse. Reused for the start/missile/left/right buttons.
// Ports:
//   pclk, rst   clock and asynchronous active-high reset
//   btn_in      raw asynchronous button level
//   sample_en   debounce sample strobe (one pulse per frame)
//   press       1-pclk pulse once the button has been high for DEB_FRAMES samples
module button_debounce #(
  parameter int unsigned DEB_FRAMES = 3
) (
  input  logic pclk,
  input  logic rst,
  input  logic btn_in,
  input  logic sample_en,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEB_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_FRAMES);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Counter parks at CNT_MAX while held, so a held button only presses once;
  // a low sample re-arms it.
  always_comb begin
    sync_d  = {sync_q[0], btn_in};
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sample_en) begin
      if (!sync_q[1]) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d   = cnt_q + CNT_W'(1);
        press_d = (cnt_q == CNT_MAX - CNT_W'(1));
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_ctrl.sv
// Frame-synchronous game sequencer: IDLE/PLAY/HIT/OVER FSM with lives, score and
// level counters. Gates ship/enemy logic via play_en and respawns them with level_reset.
// Ports:
//   pclk, rst         pixel clock, asynchronous active-high reset
//   vblnk_in          vertical blank from the timing generator
//   start_button      raw start push button
//   enemy_killed      1-pclk pulse, missile destroyed an enemy
//   ship_hit          1-pclk pulse, ship collided
//   all_enemies_dead  level, no enemies alive
//   frame_tick        1-pclk pulse at the start of vertical blank
//   state             current game state code
//   play_en           high only while playing
//   level_reset       1-pclk respawn pulse
//   lives, score, level  game counters for display
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned SCORE_W     = 10,
  parameter int unsigned HIT_FRAMES  = 60,
  parameter int unsigned OVER_FRAMES = 180,
  parameter int unsigned DEB_FRAMES  = 3
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vblnk_in,
  input  logic               start_button,
  input  logic               enemy_killed,
  input  logic               ship_hit,
  input  logic               all_enemies_dead,
  output logic               frame_tick,
  output logic [STATE_W-1:0] state,
  output logic               play_en,
  output logic               level_reset,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level
);

  localparam int unsigned FCNT_W = $clog2(OVER_FRAMES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [FCNT_W-1:0]  HIT_LAST  = FCNT_W'(HIT_FRAMES - 1);
  localparam logic [FCNT_W-1:0]  OVER_LAST = FCNT_W'(OVER_FRAMES - 1);

  logic [1:0]         vblnk_q, vblnk_d;
  logic               frame_tick_q, frame_tick_d;
  game_state_e        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               play_en_q, play_en_d;
  logic               level_reset_q, level_reset_d;
  logic               start_press;

  button_debounce #(
    .DEB_FRAMES(DEB_FRAMES)
  ) u_start_deb (
    .pclk      (pclk),
    .rst       (rst),
    .btn_in    (start_button),
    .sample_en (frame_tick_q),
    .press     (start_press)
  );

  // vblnk_in is registered once, then edge-detected; tick lands 2 pclk after the rise.
  always_comb begin
    vblnk_d      = {vblnk_q[0], vblnk_in};
    frame_tick_d = vblnk_q[0] & ~vblnk_q[1];
  end

  // Game FSM and counters.
  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    score_d       = score_q;
    level_d       = level_q;
    fcnt_d        = fcnt_q;
    level_reset_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          state_d       = ST_PLAY;
          lives_d       = LIVES_W'(LIVES_INIT);
          score_d       = '0;
          level_d       = LEVEL_FIRST;
          level_reset_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (enemy_killed && (score_q != SCORE_MAX)) begin
          score_d = score_q + SCORE_W'(1);
        end
        // A hit pre-empts a level advance on the same frame tick.
        if (ship_hit) begin
          lives_d = lives_q - LIVES_W'(1);
          fcnt_d  = '0;
          state_d = (lives_q == LIVES_W'(1)) ? ST_OVER : ST_HIT;
        end else if (frame_tick_q && all_enemies_dead) begin
          level_d       = level_inc(level_q);
          level_reset_d = 1'b1;
        end
      end
      ST_HIT: begin
        if (frame_tick_q) begin
          if (fcnt_q == HIT_LAST) begin
            state_d       = ST_PLAY;
            fcnt_d        = '0;
            level_reset_d = 1'b1;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (frame_tick_q) begin
          if (fcnt_q == OVER_LAST) begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    play_en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_q       <= '0;
      frame_tick_q  <= 1'b0;
      state_q       <= ST_IDLE;
      lives_q       <= '0;
      score_q       <= '0;
      level_q       <= '0;
      fcnt_q        <= '0;
      play_en_q     <= 1'b0;
      level_reset_q <= 1'b0;
    end else begin
      vblnk_q       <= vblnk_d;
      frame_tick_q  <= frame_tick_d;
      state_q       <= state_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      level_q       <= level_d;
      fcnt_q        <= fcnt_d;
      play_en_q     <= play_en_d;
      level_reset_q <= level_reset_d;
    end
  end

  assign frame_tick  = frame_tick_q;
  assign state       = STATE_W'(state_q);
  assign play_en     = play_en_q;
  assign level_reset = level_reset_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign level       = level_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus randomized play, checked every cycle
// against an event-level model of the game rules, with literal spot checks.
module tb_game_ctrl;

  localparam int LIVES_INIT  = 3;
  localparam int SCORE_W     = 10;
  localparam int HIT_FRAMES  = 60;
  localparam int OVER_FRAMES = 180;
  localparam int DEB_FRAMES  = 3;
  localparam int SCORE_MAX   = (1 << SCORE_W) - 1;
  localparam int FRAME_LEN   = 16;
  localparam int VBL_LEN     = 4;

  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic vblnk_in = 1'b0;
  logic start_button = 1'b0;
  logic enemy_killed = 1'b0;
  logic ship_hit = 1'b0;
  logic all_enemies_dead = 1'b0;
  logic               frame_tick;
  logic [1:0]         state;
  logic               play_en;
  logic               level_reset;
  logic [1:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [3:0]         level;

  int n_cmp = 0;
  int n_bad = 0;
  bit gen_en = 1'b0;

  game_ctrl #(
    .LIVES_INIT(LIVES_INIT), .SCORE_W(SCORE_W), .HIT_FRAMES(HIT_FRAMES),
    .OVER_FRAMES(OVER_FRAMES), .DEB_FRAMES(DEB_FRAMES)
  ) dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .start_button(start_button),
    .enemy_killed(enemy_killed), .ship_hit(ship_hit), .all_enemies_dead(all_enemies_dead),
    .frame_tick(frame_tick), .state(state), .play_en(play_en), .level_reset(level_reset),
    .lives(lives), .score(score), .level(level)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event level, per pclk edge) ----------------
  // Game state numbers: 0 idle, 1 play, 2 hit, 3 over.
  int cyc, rise_at, last_v, b1, b2, run;
  int m_tick, m_press, m_state, m_lives, m_score, m_level, m_frames, m_lr;
  int new_tick, press_now;

  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      cyc = 0; rise_at = -10; last_v = 0; b1 = 0; b2 = 0; run = 0;
      m_tick = 0; m_press = 0; m_state = 0; m_lives = 0; m_score = 0;
      m_level = 0; m_frames = 0; m_lr = 0;
    end else begin
      cyc++;
      // Button: seen through a 2-cycle synchroniser, sampled on each frame tick.
      press_now = 0;
      if (m_tick != 0) begin
        if (b2 != 0) begin
          if (run < DEB_FRAMES) begin
            run++;
            if (run == DEB_FRAMES) press_now = 1;
          end
        end else begin
          run = 0;
        end
      end
      // Game rules react to the previous cycle's tick and press.
      m_lr = 0;
      case (m_state)
        0: if (m_press != 0) begin
             m_state = 1; m_lives = LIVES_INIT; m_score = 0; m_level = 1; m_lr = 1;
           end
        1: begin
             if (enemy_killed) m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
             if (ship_hit) begin
               m_lives = m_lives - 1;
               m_frames = 0;
               m_state = (m_lives == 0) ? 3 : 2;
             end else if (m_tick != 0 && all_enemies_dead) begin
               m_level = (m_level < 15) ? m_level + 1 : 15;
               m_lr = 1;
             end
           end
        2: if (m_tick != 0) begin
             m_frames++;
             if (m_frames == HIT_FRAMES) begin m_state = 1; m_lr = 1; end
           end
        default: if (m_tick != 0) begin
             m_frames++;
             if (m_frames == OVER_FRAMES) m_state = 0;
           end
      endcase
      // Tick is due the cycle after the first cycle vblnk_in is seen high.
      new_tick = (rise_at == cyc - 1) ? 1 : 0;
      if (vblnk_in && last_v == 0) rise_at = cyc;
      last_v = vblnk_in ? 1 : 0;
      b2 = b1;
      b1 = start_button ? 1 : 0;
      m_tick = new_tick;
      m_press = press_now;
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge pclk) begin
    if (!rst) begin
      check("frame_tick", int'(frame_tick), m_tick);
      check("state", int'(state), m_state);
      check("play_en", int'(play_en), (m_state == 1) ? 1 : 0);
      check("level_reset", int'(level_reset), m_lr);
      check("lives", int'(lives), m_lives);
      check("score", int'(score), m_score);
      check("level", int'(level), m_level);
    end
  end

  // Periodic frame generator.
  initial begin
    wait (gen_en);
    forever begin
      repeat (FRAME_LEN - VBL_LEN) @(negedge pclk);
      vblnk_in = 1'b1;
      repeat (VBL_LEN) @(negedge pclk);
      vblnk_in = 1'b0;
    end
  end

  // Returns at the negedge where frame_tick is visible.
  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (frame_tick !== 1'b1 && n < 4 * FRAME_LEN);
    check(name, int'(frame_tick), 1);
  endtask

  task automatic wait_lr(input string name);
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (level_reset !== 1'b1 && n < 10 * FRAME_LEN);
    check(name, int'(level_reset), 1);
  endtask

  task automatic pulse_kill();
    @(negedge pclk); enemy_killed = 1'b1;
    @(negedge pclk); enemy_killed = 1'b0;
  endtask

  task automatic pulse_hit();
    @(negedge pclk); ship_hit = 1'b1;
    @(negedge pclk); ship_hit = 1'b0;
  endtask

  int ntk, lat;

  initial begin
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    check("rst_state", int'(state), 0);
    check("rst_lives", int'(lives), 0);
    check("rst_score", int'(score), 0);
    check("rst_level", int'(level), 0);
    check("rst_play_en", int'(play_en), 0);

    // Long vertical blank: one tick, two pclk after the rise.
    vblnk_in = 1'b1;
    ntk = 0;
    lat = -1;
    for (int i = 1; i <= 380; i++) begin
      @(negedge pclk);
      if (frame_tick) begin
        ntk++;
        if (lat < 0) lat = i;
      end
    end
    vblnk_in = 1'b0;
    check("tick_count", ntk, 1);
    check("tick_latency", lat, 2);
    repeat (5) @(negedge pclk);
    gen_en = 1'b1;

    // Bounce: high for 2 samples, then low, must not start.
    wait_tick("bounce_sync");
    start_button = 1'b1;
    wait_tick("bounce_t1");
    wait_tick("bounce_t2");
    start_button = 1'b0;
    wait_tick("bounce_t3");
    wait_tick("bounce_t4");
    @(negedge pclk);
    check("bounce_no_start", int'(state), 0);

    // Clean press.
    start_button = 1'b1;
    wait_lr("start_lr");
    check("start_state", int'(state), 1);
    check("start_lives", int'(lives), 3);
    check("start_level", int'(level), 1);
    check("start_score", int'(score), 0);
    check("start_play_en", int'(play_en), 1);
    wait_tick("held_t1");
    wait_tick("held_t2");
    start_button = 1'b0;
    @(negedge pclk);
    check("held_no_restart", int'(lives), 3);

    // Five kills then a hit.
    repeat (5) pulse_kill();
    pulse_hit();
    check("hit_score", int'(score), 5);
    check("hit_lives", int'(lives), 2);
    check("hit_state", int'(state), 2);
    check("hit_play_en", int'(play_en), 0);
    for (int i = 0; i < HIT_FRAMES; i++) begin
      wait_tick("hit_wait");
      @(negedge pclk);
      if (i == HIT_FRAMES - 2) check("hit_still", int'(state), 2);
    end
    check("respawn_state", int'(state), 1);
    check("respawn_lr", int'(level_reset), 1);
    check("respawn_level", int'(level), 1);

    // Level climb to the ceiling.
    all_enemies_dead = 1'b1;
    for (int i = 0; i < 14; i++) begin
      wait_tick("lvl_up");
      @(negedge pclk);
    end
    check("level_15", int'(level), 15);
    wait_tick("lvl_sat");
    @(negedge pclk);
    check("level_sat", int'(level), 15);
    check("level_sat_lr", int'(level_reset), 1);
    // Hit on the same tick as all_enemies_dead.
    wait_tick("lvl_hit");
    ship_hit = 1'b1;
    @(negedge pclk);
    ship_hit = 1'b0;
    check("tie_state", int'(state), 2);
    check("tie_level", int'(level), 15);
    check("tie_lr", int'(level_reset), 0);
    check("tie_lives", int'(lives), 1);
    all_enemies_dead = 1'b0;

    // Back to play, third hit ends the game.
    for (int i = 0; i < HIT_FRAMES; i++) wait_tick("hit2_wait");
    @(negedge pclk);
    check("respawn2_state", int'(state), 1);
    pulse_hit();
    check("over_state", int'(state), 3);
    check("over_lives", int'(lives), 0);
    pulse_kill();
    check("over_kill_ignored", int'(score), 5);
    for (int i = 0; i < OVER_FRAMES; i++) begin
      wait_tick("over_wait");
      @(negedge pclk);
      if (i == OVER_FRAMES - 2) check("over_still", int'(state), 3);
    end
    check("idle_state", int'(state), 0);
    check("idle_score_held", int'(score), 5);
    check("idle_level_held", int'(level), 15);
    check("idle_lives", int'(lives), 0);

    // Asynchronous reset in the middle of a game.
    start_button = 1'b1;
    wait_lr("restart_lr");
    start_button = 1'b0;
    pulse_kill();
    pulse_kill();
    check("restart_score", int'(score), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_score", int'(score), 0);
    check("arst_lives", int'(lives), 0);
    check("arst_play_en", int'(play_en), 0);
    check("arst_level", int'(level), 0);
    @(negedge pclk);
    rst = 1'b0;

    // Randomized play.
    for (int i = 0; i < 8000; i++) begin
      @(negedge pclk);
      enemy_killed = ($urandom_range(3) == 0);
      ship_hit = ($urandom_range(199) == 0);
      if ($urandom_range(63) == 0) all_enemies_dead = ~all_enemies_dead;
      if ($urandom_range(39) == 0) start_button = ~start_button;
      if (i == 5000) begin
        #2 rst = 1'b1;
        #1;
        check("rand_arst_state", int'(state), 0);
        @(negedge pclk);
        rst = 1'b0;
      end
    end
    enemy_killed = 1'b0;
    ship_hit = 1'b0;
    repeat (4) @(negedge pclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
